data_addr_gen: RTL and testbench

Data address generator (DAG) for the FIR DSP datapath. It holds 8 independent circular-buffer descriptors, each with a base, length, signed power-of-two stride and a live offset. On each read strobe it emits the selected buffer's current address on a registered output, then post-modifies that buffer's pointer with wrap-around. It sits between the sequencer, which configures and strobes it, and the data memory address port.

---
 rtl/data_addr_gen_if.sv | 21 ++
 rtl/data_addr_gen.sv | 119 +++++++++++
 tb/tb_data_addr_gen.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/data_addr_gen_if.sv
// Sequencer-to-DAG bus: read/write strobes, buffer select, descriptor word and generated address.
// Carries the optional wrap flag when DAG_WRAP_FLAG_EN is defined.
interface data_addr_gen_if #(
    parameter int ADDR_W = 16,
    parameter int LEN_W  = 12
);
    logic                     re;
    logic                     we;
    logic [2:0]               cbs;
    logic [ADDR_W+LEN_W+3:0]  wd;
    logic [ADDR_W-1:0]        a;
`ifdef DAG_WRAP_FLAG_EN
    logic                     wrap;

    modport master (output re, we, cbs, wd, input  a, wrap);
    modport slave  (input  re, we, cbs, wd, output a, wrap);
`else
    modport master (output re, we, cbs, wd, input  a);
    modport slave  (input  re, we, cbs, wd, output a);
`endif
endinterface

// File: rtl/data_addr_gen.sv
// Eight-descriptor circular-buffer address generator with registered address and post-modify wrap.
// Optional feature macro: DAG_WRAP_FLAG_EN adds a registered wrap flag on the bus.
module data_addr_gen #(
    parameter int ADDR_W = 16,
    parameter int LEN_W  = 12
) (
    input  logic           clk,
    input  logic           rst_n,
    data_addr_gen_if.slave bus
);
    localparam int NBUF = 8;
    localparam int EW   = LEN_W + 2;

    logic [ADDR_W-1:0] base_q [NBUF];
    logic [LEN_W-1:0]  len_q  [NBUF];
    logic              sign_q [NBUF];
    logic [2:0]        exp_q  [NBUF];
    logic [LEN_W-1:0]  off_q  [NBUF];
    logic [ADDR_W-1:0] a_q;

    logic [ADDR_W-1:0] cur_base;
    logic [LEN_W-1:0]  cur_len;
    logic [LEN_W-1:0]  cur_off;
    logic              cur_sign;
    logic [EW-1:0]     stride;
    logic [EW-1:0]     ext_off;
    logic [EW-1:0]     ext_len;
    logic [EW-1:0]     sum;
    logic [LEN_W-1:0]  off_d;
    logic [ADDR_W-1:0] a_d;
`ifdef DAG_WRAP_FLAG_EN
    logic              wrap_q;
    logic              wrap_d;
`endif

    always_comb begin
        cur_base = base_q[bus.cbs];
        cur_len  = len_q[bus.cbs];
        cur_off  = off_q[bus.cbs];
        cur_sign = sign_q[bus.cbs];
        stride   = '0;
        stride[exp_q[bus.cbs]] = 1'b1;
        ext_off  = {2'b00, cur_off};
        ext_len  = {2'b00, cur_len};
        sum      = '0;
`ifdef DAG_WRAP_FLAG_EN
        wrap_d   = 1'b0;
`endif
        // Two extra bits keep off+len and off+stride exact before the wrap tests.
        if (cur_len != '0) begin
            if (!cur_sign) begin
                sum = ext_off + stride;
                if (sum >= ext_len) begin
                    sum = sum - ext_len;
`ifdef DAG_WRAP_FLAG_EN
                    wrap_d = 1'b1;
`endif
                end
                if (sum >= ext_len) sum = '0;
            end else if (ext_off >= stride) begin
                sum = ext_off - stride;
            end else begin
`ifdef DAG_WRAP_FLAG_EN
                wrap_d = 1'b1;
`endif
                sum = ext_off + ext_len;
                if (sum < stride) begin
                    sum = '0;
                end else begin
                    sum = sum - stride;
                    if (sum >= ext_len) sum = '0;
                end
            end
        end
        off_d = LEN_W'(sum);
        a_d   = cur_base + ADDR_W'(cur_off);
    end

    // Write takes priority over a coincident read; the address register only moves on reads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NBUF; i++) begin
                base_q[i] <= '0;
                len_q[i]  <= '0;
                sign_q[i] <= 1'b0;
                exp_q[i]  <= '0;
                off_q[i]  <= '0;
            end
            a_q <= '0;
`ifdef DAG_WRAP_FLAG_EN
            wrap_q <= 1'b0;
`endif
        end else if (bus.we) begin
            base_q[bus.cbs] <= bus.wd[ADDR_W+LEN_W+3:LEN_W+4];
            len_q[bus.cbs]  <= bus.wd[LEN_W+3:4];
            sign_q[bus.cbs] <= bus.wd[3];
            exp_q[bus.cbs]  <= bus.wd[2:0];
            off_q[bus.cbs]  <= '0;
`ifdef DAG_WRAP_FLAG_EN
            wrap_q <= 1'b0;
`endif
        end else if (bus.re) begin
            a_q            <= a_d;
            off_q[bus.cbs] <= off_d;
`ifdef DAG_WRAP_FLAG_EN
            wrap_q <= wrap_d;
`endif
        end else begin
`ifdef DAG_WRAP_FLAG_EN
            wrap_q <= 1'b0;
`endif
        end
    end

    assign bus.a = a_q;
`ifdef DAG_WRAP_FLAG_EN
    assign bus.wrap = wrap_q;
`endif
endmodule

// File: tb/tb_data_addr_gen.sv
// Self-checking bench for data_addr_gen: directed plan cases plus randomized traffic vs an arithmetic model.
module tb_data_addr_gen;
    logic clk;
    logic rst_n;
    data_addr_gen_if bus ();

    data_addr_gen dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp;
    int n_err;

    int m_base [8];
    int m_len  [8];
    int m_sign [8];
    int m_exp  [8];
    int m_off  [8];
    int m_a;
    int m_wrap;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            m_base[i] = 0; m_len[i] = 0; m_sign[i] = 0; m_exp[i] = 0; m_off[i] = 0;
        end
        m_a = 0;
        m_wrap = 0;
    endtask

    task automatic model_step(input logic w, input logic r, input logic [2:0] s, input logic [31:0] d);
        int st;
        int n;
        m_wrap = 0;
        if (w) begin
            m_base[s] = int'(d[31:16]);
            m_len[s]  = int'(d[15:4]);
            m_sign[s] = int'(d[3]);
            m_exp[s]  = int'(d[2:0]);
            m_off[s]  = 0;
        end else if (r) begin
            m_a = (m_base[s] + m_off[s]) % 65536;
            st  = 1 << m_exp[s];
            n   = 0;
            if (m_len[s] > 0) begin
                if (m_sign[s] == 0) begin
                    n = m_off[s] + st;
                    if (n >= m_len[s]) begin n = n - m_len[s]; m_wrap = 1; end
                    if (n >= m_len[s]) n = 0;
                end else begin
                    if (m_off[s] >= st) n = m_off[s] - st;
                    else begin n = m_off[s] + m_len[s] - st; m_wrap = 1; end
                    if (n < 0 || n >= m_len[s]) n = 0;
                end
            end
            m_off[s] = n;
        end
    endtask

    // One clock: present inputs, take the edge, update the model, check outputs 1 time unit later.
    task automatic cyc(input logic w, input logic r, input logic [2:0] s, input logic [31:0] d);
        bus.we = w; bus.re = r; bus.cbs = s; bus.wd = d;
        @(posedge clk);
        #1;
        model_step(w, r, s, d);
        bus.we = 1'b0; bus.re = 1'b0;
        check("a_model", 32'(bus.a), 32'(m_a));
`ifdef DAG_WRAP_FLAG_EN
        check("wrap_model", 32'(bus.wrap), 32'(m_wrap));
`endif
    endtask

    task automatic wr(input logic [2:0] s, input logic [31:0] d);
        cyc(1'b1, 1'b0, s, d);
    endtask

    task automatic rd(input logic [2:0] s, input logic [15:0] plan);
        cyc(1'b0, 1'b1, s, 32'h0);
        check("a_plan", 32'(bus.a), 32'(plan));
    endtask

    initial begin
        logic [31:0] d;
        logic        w;
        logic        r;
        n_cmp = 0;
        n_err = 0;
        model_reset();
        rst_n = 1'b0;
        bus.we = 1'b0; bus.re = 1'b0; bus.cbs = 3'd0; bus.wd = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_a", 32'(bus.a), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        wr(3'd0, 32'hAB00_0081);
        rd(3'd0, 16'hAB00);
        rd(3'd0, 16'hAB02);
        rd(3'd0, 16'hAB04);
        rd(3'd0, 16'hAB06);
`ifdef DAG_WRAP_FLAG_EN
        check("wrap_plan", 32'(bus.wrap), 32'h1);
`endif
        rd(3'd0, 16'hAB00);

        wr(3'd1, 32'h1000_0058);
        rd(3'd1, 16'h1000);
        rd(3'd1, 16'h1004);
        rd(3'd1, 16'h1003);
        rd(3'd1, 16'h1002);
        rd(3'd1, 16'h1001);
        rd(3'd1, 16'h1000);

        wr(3'd2, 32'h2000_0062);
        wr(3'd3, 32'h3000_0040);
        rd(3'd2, 16'h2000);
        rd(3'd3, 16'h3000);
        rd(3'd2, 16'h2004);
        rd(3'd3, 16'h3001);

        rd(3'd0, 16'hAB02);
        rd(3'd0, 16'hAB04);
        wr(3'd0, 32'hC000_0081);
        check("a_hold_on_write", 32'(bus.a), 32'hAB04);
        rd(3'd0, 16'hC000);
        cyc(1'b1, 1'b1, 3'd0, 32'hC000_0081);
        check("a_hold_re_we", 32'(bus.a), 32'hC000);
        rd(3'd0, 16'hC000);

        wr(3'd4, 32'hFFFE_0041);
        rd(3'd4, 16'hFFFE);
        rd(3'd4, 16'h0000);
        wr(3'd5, 32'h5555_0003);
        rd(3'd5, 16'h5555);
        rd(3'd5, 16'h5555);
        rd(3'd5, 16'h5555);
        rd(3'd6, 16'h0000);

        // Asynchronous reset asserted between edges.
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_a", 32'(bus.a), 32'h0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) rd(3'(i), 16'h0000);

        for (int k = 0; k < 600; k++) begin
            d = $urandom;
            if ($urandom_range(0, 3) != 0) d[15:4] = 12'($urandom_range(0, 20));
            w = ($urandom_range(0, 7) == 0);
            r = ($urandom_range(0, 1) == 1);
            cyc(w, r, 3'($urandom_range(0, 7)), d);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
